ofdm_qam_framer: RTL

Downstream neighbour of the bit-source ROM stage. Accepts 2-bit (QPSK) or 4-bit (16-QAM) symbols on the `idata`/`valid_rom` interface and maps them to signed I/Q constellation points. Assembles N_FFT-subcarrier OFDM frames, inserting DC/guard nulls and polarity-toggling pilots. Streams frames to the IFFT with a valid/ready handshake, buffering through a small FIFO so upstream backpressure stays one cycle late-tolerant.

---
 rtl/ofdm_qam_framer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ofdm_qam_framer.sv
// OFDM frame assembler: QPSK/16-QAM symbol mapping, null/pilot insertion and a
// small input FIFO in front of a valid/ready output register feeding the IFFT.
module ofdm_qam_framer #(
   parameter int N_FFT       = 64,
   parameter int OUT_WIDTH   = 16,
   parameter int GUARD_LEFT  = 5,
   parameter int GUARD_RIGHT = 5,
   parameter int PILOT_STEP  = 8,
   parameter int QPSK_AMP    = 5793,
   parameter int QAM_UNIT    = 2590,
   parameter int PILOT_AMP   = 5793,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        en,
   input  logic                        mod_switch,
   input  logic [3:0]                  idata,
   input  logic                        valid_rom,
   output logic                        ready_out,
   input  logic                        out_ready,
   output logic                        out_valid,
   output logic signed [OUT_WIDTH-1:0] out_i,
   output logic signed [OUT_WIDTH-1:0] out_q,
   output logic [$clog2(N_FFT)-1:0]    out_index,
   output logic                        out_sof,
   output logic                        out_eof,
   output logic                        overflow,
   output logic                        busy
);
   localparam int KW = $clog2(N_FFT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [KW-1:0] K_LAST = KW'(N_FFT - 1);
   localparam logic signed [OUT_WIDTH-1:0] C_QPSK = OUT_WIDTH'(QPSK_AMP);
   localparam logic signed [OUT_WIDTH-1:0] C_U1   = OUT_WIDTH'(QAM_UNIT);
   localparam logic signed [OUT_WIDTH-1:0] C_U3   = OUT_WIDTH'(3 * QAM_UNIT);
   localparam logic signed [OUT_WIDTH-1:0] C_PIL  = OUT_WIDTH'(PILOT_AMP);

   typedef enum logic {S_IDLE, S_RUN} state_t;
   state_t r_state, w_state_next;

   logic [3:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_count;
   logic          r_ovf;
   logic          w_empty, w_full, w_push, w_pop;
   logic [3:0]    w_head;

   logic [KW-1:0]                r_k;
   logic                         r_mode, r_pol;
   logic                         r_out_valid, r_sof, r_eof;
   logic signed [OUT_WIDTH-1:0]  r_out_i, r_out_q;
   logic [KW-1:0]                r_out_index;
   logic                         w_slot, w_load;
   logic                         w_null, w_pilot, w_data;
   logic [31:0]                  w_kval;
   logic signed [OUT_WIDTH-1:0]  w_pt_i, w_pt_q;

   function automatic logic signed [OUT_WIDTH-1:0] qam_level(input logic [1:0] b);
      case (b)
         2'b00:   return -C_U3;
         2'b01:   return -C_U1;
         2'b11:   return C_U1;
         default: return C_U3;
      endcase
   endfunction

   function automatic logic signed [OUT_WIDTH-1:0] qpsk_level(input logic b);
      return b ? -C_QPSK : C_QPSK;
   endfunction

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CW'(FIFO_DEPTH));
   assign w_push    = valid_rom & ~w_full;
   assign w_head    = r_mem[r_rptr];
   assign ready_out = (CW'(FIFO_DEPTH) - r_count) >= CW'(2);

   always_ff @(posedge clk) begin
      if (reset && w_push) r_mem[r_wptr] <= idata;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (valid_rom && w_full) r_ovf <= 1'b1;
      end
   end

   assign w_kval  = 32'(r_k);
   assign w_null  = (r_k == '0) ||
                    (w_kval >= 32'(N_FFT/2 - GUARD_LEFT) && w_kval <= 32'(N_FFT/2 + GUARD_RIGHT));
   assign w_pilot = ~w_null && ((w_kval % 32'(PILOT_STEP)) == 32'(PILOT_STEP/2));
   assign w_data  = ~w_null & ~w_pilot;
   assign w_slot  = ~r_out_valid | out_ready;

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // Data carriers only load when a symbol is waiting; otherwise the slot bubbles and k holds.
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_pop        = 1'b0;
      w_pt_i       = '0;
      w_pt_q       = '0;
      if (w_pilot) begin
         w_pt_i = r_pol ? -C_PIL : C_PIL;
      end else if (w_data) begin
         if (r_mode) begin
            w_pt_i = qam_level(w_head[3:2]);
            w_pt_q = qam_level(w_head[1:0]);
         end else begin
            w_pt_i = qpsk_level(w_head[1]);
            w_pt_q = qpsk_level(w_head[0]);
         end
      end
      case (r_state)
         S_IDLE: if (en && !w_empty) w_state_next = S_RUN;
         S_RUN: begin
            if (w_slot && (!w_data || !w_empty)) begin
               w_load = 1'b1;
               w_pop  = w_data;
               if (r_k == K_LAST && !en) w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_k         <= '0;
         r_mode      <= 1'b0;
         r_pol       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_i     <= '0;
         r_out_q     <= '0;
         r_out_index <= '0;
         r_sof       <= 1'b0;
         r_eof       <= 1'b0;
      end else begin
         if (r_state == S_IDLE && w_state_next == S_RUN) begin
            r_mode <= mod_switch;
            r_k    <= '0;
         end
         if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_i     <= w_pt_i;
            r_out_q     <= w_pt_q;
            r_out_index <= r_k;
            r_sof       <= (r_k == '0);
            r_eof       <= (r_k == K_LAST);
            r_k         <= r_k + KW'(1);
            if (r_k == K_LAST) begin
               r_pol <= ~r_pol;
               if (en) r_mode <= mod_switch;
            end
         end else if (w_slot) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_i     = r_out_i;
   assign out_q     = r_out_q;
   assign out_index = r_out_index;
   assign out_sof   = r_sof;
   assign out_eof   = r_eof;
   assign overflow  = r_ovf;
   assign busy      = (r_state == S_RUN);
endmodule
